// File: rtl/gpio_in_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_capture_if : pin, edge-enable, clear and status signals.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface gpio_in_capture_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic             clr_valid;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] value_out;
  logic [WIDTH-1:0] pending;
  logic             irq;
  logic             done;

  modport master (
    output pin_in, rise_en, fall_en, clr_valid, clr_mask,
    input  value_out, pending, irq, done
  );

  modport slave (
    input  pin_in, rise_en, fall_en, clr_valid, clr_mask,
    output value_out, pending, irq, done
  );
endinterface
`default_nettype wire

// File: rtl/gpio_in_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_capture : synchronise, debounce and latch edges on GPIO pins.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gpio_in_capture #(
  parameter int WIDTH  = 8,
  parameter int DIV    = 50000,
  parameter int STABLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  gpio_in_capture_if.slave   bus
);
  localparam int PW = $clog2(DIV);
  localparam int SW = $clog2(STABLE);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             tick_w;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             irq_q, done_q;
  logic [WIDTH-1:0] flip_w, set_w, clr_w;

  assign tick_w = (cnt_q == PW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (tick_w) cnt_d = '0;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [SW-1:0] stab_q, stab_d;
    logic          disagree_w;

    assign disagree_w = sync2_q[i] ^ value_q[i];
    assign flip_w[i]  = tick_w & disagree_w & (stab_q == SW'(STABLE - 1));

    // Any agreeing tick, or the accepting tick itself, restarts the run.
    always_comb begin
      stab_d = stab_q;
      if (tick_w) begin
        if (!disagree_w || flip_w[i]) stab_d = '0;
        else                          stab_d = stab_q + SW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) stab_q <= '0;
      else     stab_q <= stab_d;
    end
  end

  // A set on the same bit as a clear takes priority.
  always_comb begin
    clr_w     = bus.clr_valid ? bus.clr_mask : '0;
    set_w     = flip_w & ((~value_q & bus.rise_en) | (value_q & bus.fall_en));
    pending_d = (pending_q & ~clr_w) | set_w;
    value_d   = value_q ^ flip_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= bus.pin_in;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      pending_q <= pending_d;
      irq_q     <= |pending_d;
      done_q    <= |flip_w;
    end
  end

  assign bus.value_out = value_q;
  assign bus.pending   = pending_q;
  assign bus.irq       = irq_q;
  assign bus.done      = done_q;
endmodule
`default_nettype wire

// File: tb/tb_gpio_in_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_in_capture : directed and random stimulus against a model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_gpio_in_capture;
  localparam int W      = 8;
  localparam int DIV    = 4;
  localparam int STABLE = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_in_capture_if #(.WIDTH(W)) bus ();

  gpio_in_capture #(.WIDTH(W), .DIV(DIV), .STABLE(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors  = 0;
  int fails    = 0;
  int done_cnt = 0;

  // Reference: pins reach the filter two edges late; a bit flips once the
  // last STABLE tick samples since reset all disagree with its value.
  logic [W-1:0]        m_d1, m_d2, m_val, m_pend;
  logic                m_irq, m_done;
  int                  m_cyc, m_nt;
  logic [STABLE-1:0]   m_win [W];

  function automatic logic [W-1:0] flip_next();
    logic [W-1:0]      f;
    logic [STABLE-1:0] w;
    f = '0;
    if ((m_cyc % DIV) == DIV - 1 && m_nt + 1 >= STABLE) begin
      for (int b = 0; b < W; b++) begin
        w = {m_win[b][STABLE-2:0], m_d2[b]};
        if (w == {STABLE{~m_val[b]}}) f[b] = 1'b1;
      end
    end
    return f;
  endfunction

  function automatic int run_len(int b);
    int r;
    r = 0;
    for (int k = 0; k < STABLE; k++) begin
      if (k < m_nt && m_win[b][k] != m_val[b]) r++;
      else break;
    end
    return r;
  endfunction

  task automatic model_edge();
    logic [W-1:0] f, clr;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_val = '0; m_pend = '0;
      m_irq = 1'b0; m_done = 1'b0; m_cyc = 0; m_nt = 0;
      for (int b = 0; b < W; b++) m_win[b] = '0;
    end else begin
      f   = flip_next();
      clr = bus.clr_valid ? bus.clr_mask : '0;
      if ((m_cyc % DIV) == DIV - 1) begin
        for (int b = 0; b < W; b++) m_win[b] = {m_win[b][STABLE-2:0], m_d2[b]};
        m_nt++;
      end
      m_pend = (m_pend & ~clr) | (f & ((~m_val & bus.rise_en) | (m_val & bus.fall_en)));
      m_val  = m_val ^ f;
      m_irq  = |m_pend;
      m_done = |f;
      m_d2   = m_d1;
      m_d1   = bus.pin_in;
      m_cyc++;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.done === 1'b1) done_cnt++;
    chk("value_out", 32'(bus.value_out), 32'(m_val));
    chk("pending",   32'(bus.pending),   32'(m_pend));
    chk("irq",       32'(bus.irq),       32'(m_irq));
    chk("done",      32'(bus.done),      32'(m_done));
  endtask

  task automatic wait_bit(int b, logic target, int max, string tag, output int n);
    n = 0;
    while (bus.value_out[b] !== target && n < max) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.value_out[b]), 32'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n, d0;
    logic [W-1:0] v0, p0, fn;

    rst = 1'b1;
    bus.pin_in = '0; bus.rise_en = '0; bus.fall_en = '0;
    bus.clr_valid = 1'b0; bus.clr_mask = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_value", 32'(bus.value_out), 32'h0);
    chk("rst_pend",  32'(bus.pending),   32'h0);
    chk("rst_irq",   32'(bus.irq),       32'h0);
    chk("rst_done",  32'(bus.done),      32'h0);

    // Clean rising step on bit 0.
    bus.rise_en = 8'h01;
    bus.pin_in[0] = 1'b1;
    d0 = done_cnt;
    wait_bit(0, 1'b1, 30, "rise0", n);
    chk("lat_rise0", 32'(n >= 11 && n <= 18), 32'h1);
    repeat (3) step();
    chk("pend_rise0", 32'(bus.pending), 32'h01);
    chk("irq_rise0",  32'(bus.irq),     32'h1);
    chk("done_rise0", 32'(done_cnt - d0), 32'h1);

    // Short glitch on bit 1.
    v0 = bus.value_out; p0 = bus.pending; d0 = done_cnt;
    bus.pin_in[1] = 1'b1;
    repeat (5) step();
    bus.pin_in[1] = 1'b0;
    repeat (20) step();
    chk("glitch_val",  32'(bus.value_out), 32'(v0));
    chk("glitch_pend", 32'(bus.pending),   32'(p0));
    chk("glitch_done", 32'(done_cnt - d0), 32'h0);

    // Bouncing bit 2, then a steady level.
    d0 = done_cnt;
    for (int k = 0; k < 10; k++) begin
      bus.pin_in[2] = ~k[0];
      repeat (6) step();
    end
    chk("bounce_val",  32'(bus.value_out[2]), 32'h0);
    chk("bounce_done", 32'(done_cnt - d0), 32'h0);
    bus.pin_in[2] = 1'b1;
    wait_bit(2, 1'b1, 30, "steady2", n);
    chk("lat_steady2", 32'(n >= 11 && n <= 18), 32'h1);

    // Clear coinciding with a fresh rising flip on bit 0: set wins.
    bus.pin_in[0] = 1'b0;
    wait_bit(0, 1'b0, 30, "fall0", n);
    chk("pend_after_fall0", 32'(bus.pending), 32'h01);
    bus.pin_in[0] = 1'b1;
    n = 0;
    fn = flip_next();
    while (!fn[0] && n < 30) begin
      step();
      n++;
      fn = flip_next();
    end
    chk("flip0_predicted", 32'(fn[0]), 32'h1);
    bus.clr_valid = 1'b1; bus.clr_mask = 8'h01;
    step();
    bus.clr_valid = 1'b0; bus.clr_mask = '0;
    chk("setwins_val",  32'(bus.value_out[0]), 32'h1);
    chk("setwins_pend", 32'(bus.pending), 32'h01);
    bus.clr_valid = 1'b1; bus.clr_mask = 8'h01;
    step();
    bus.clr_valid = 1'b0; bus.clr_mask = '0;
    chk("clr_pend", 32'(bus.pending), 32'h00);
    chk("clr_irq",  32'(bus.irq),     32'h0);

    // Falling-only enable on bit 3.
    bus.rise_en = 8'h00; bus.fall_en = 8'h08;
    d0 = done_cnt;
    bus.pin_in[3] = 1'b1;
    wait_bit(3, 1'b1, 30, "rise3", n);
    step();
    chk("rise3_pend", 32'(bus.pending[3]), 32'h0);
    chk("rise3_done", 32'(done_cnt - d0), 32'h1);
    bus.pin_in[3] = 1'b0;
    wait_bit(3, 1'b0, 30, "fall3", n);
    chk("fall3_pend", 32'(bus.pending), 32'h08);

    // Reset in the middle of a debounce on bit 4, pin held through it.
    bus.rise_en = 8'h10; bus.fall_en = 8'h00;
    bus.pin_in[4] = 1'b1;
    n = 0;
    while (run_len(4) != 2 && n < 40) begin
      step();
      n++;
    end
    chk("run4_reached", 32'(run_len(4)), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_value", 32'(bus.value_out), 32'h0);
    chk("midrst_pend",  32'(bus.pending),   32'h0);
    chk("midrst_irq",   32'(bus.irq),       32'h0);
    chk("midrst_done",  32'(bus.done),      32'h0);
    wait_bit(4, 1'b1, 40, "rise4", n);
    chk("ticks4", 32'(m_nt), 32'd3);
    chk("pend4",  32'(bus.pending), 32'h10);

    // Random pins, enables and clears.
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        bus.rise_en = W'($urandom);
        bus.fall_en = W'($urandom);
      end
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 29) == 0) bus.pin_in[b] = ~bus.pin_in[b];
      bus.clr_valid = ($urandom_range(0, 7) == 0);
      bus.clr_mask  = W'($urandom);
      step();
    end
    bus.clr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/gpio_in_capture.md
GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

Interface
REQ-001 Parameter WIDTH, default 8: number of input pins.
REQ-002 Parameter DIV, default 50000: clk cycles per sample tick; legal range 2..2^20.
REQ-003 Parameter STABLE, default 4: consecutive differing samples needed to accept a change; legal range 2..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 pin_in  input  WIDTH  raw asynchronous board inputs (buttons/switches).
REQ-007 rise_en  input  WIDTH  per-bit enable to latch rising debounced edges.
REQ-008 fall_en  input  WIDTH  per-bit enable to latch falling debounced edges.
REQ-009 clr_valid  input  1  one-cycle request to clear pending bits.
REQ-010 clr_mask  input  WIDTH  bits to clear when clr_valid=1.
REQ-011 value_out  output  WIDTH  debounced pin value.
REQ-012 pending  output  WIDTH  latched qualifying edges.
REQ-013 irq  output  1  high while any pending bit is set.
REQ-014 done  output  1  one-cycle pulse when any value_out bit changes.

Function
REQ-015 Each pin_in bit SHALL pass through a 2-flop synchronizer; the second flop output (sync) is the only form of pin_in used internally.
REQ-016 Prescaler counter: 0..DIV-1, increments every cycle, wraps to 0; tick=1 exactly in the cycle the counter equals DIV-1.
REQ-017 Per bit, a stability counter (width ceil(log2(STABLE))) SHALL update only on tick cycles.
REQ-018 On tick, sync == value_out bit: stability counter cleared to 0.
REQ-019 On tick, sync != value_out bit and counter < STABLE-1: counter increments.
REQ-020 On tick, sync != value_out bit and counter == STABLE-1: value_out bit inverts at that edge and counter clears.
REQ-021 A change therefore requires STABLE consecutive ticks of disagreement; any agreeing tick restarts the count.
REQ-022 Rising flip with rise_en bit=1, or falling flip with fall_en bit=1: the pending bit SHALL set at the same edge as the value_out flip.
REQ-023 clr_valid=1: pending bits selected by clr_mask SHALL clear at that edge; clr_mask is ignored when clr_valid=0.
REQ-024 Set and clear on the same bit in the same cycle: set wins (pending stays/becomes 1).
REQ-025 Pending bits SHALL persist until cleared; repeated edges on a set bit leave it 1 (no counting).
REQ-026 irq SHALL equal OR of pending at all times (registered alongside pending, no extra latency).
REQ-027 done SHALL be 1 for exactly the cycle following any value_out bit flip, regardless of rise_en/fall_en; it is 0 otherwise.
REQ-028 Changing rise_en/fall_en SHALL NOT retroactively set or clear pending.
REQ-029 Latency pin_in change to value_out: at least 2+(STABLE-1)*DIV+1 and at most 2+(STABLE+1)*DIV cycles for a clean step.

Reset
REQ-030 rst=1 at a clock edge SHALL zero synchronizer flops, prescaler, stability counters, value_out, pending, irq and done.
REQ-031 rst asserted mid-debounce SHALL abandon the partial count; after release counting restarts from 0 with value_out=0.
REQ-032 A pin held high through reset SHALL be accepted as a rising edge (pending set if rise_en) once debounced after release.

Verification (WIDTH=8, DIV=4, STABLE=3)
REQ-033 After reset, step pin_in[0] 0->1 and hold, rise_en=8'h01 -> value_out[0]=1 within 11..18 cycles, pending=8'h01, irq=1, done pulses once.
REQ-034 pin_in[1] high for 5 cycles then low -> value_out, pending, done unchanged (glitch rejected).
REQ-035 pin_in[2] toggles every 6 cycles for 60 cycles -> no value_out[2] change; then held high -> change after 3 ticks.
REQ-036 pending=8'h01; clr_valid=1, clr_mask=8'h01 on the same edge a new pin_in[0] rising flip sets bit 0 -> pending stays 8'h01; next clear with no edge -> pending=8'h00, irq=0.
REQ-037 fall_en=8'h08, rise_en=0: pin_in[3] debounced 0->1 -> pending[3]=0, done pulses; then 1->0 -> pending[3]=1.
REQ-038 Assert rst for one cycle when stability counter of bit 4 equals 2 -> all outputs 0 next cycle; value_out[4] flips only after 3 further full ticks.
